// File: rtl/bcd_pkg.sv
// Shared BCD types, range constants and the load-digit clamp.
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   // Non-decimal nibbles (A..F) saturate to 9 so the count stays valid BCD.
   function automatic bcd_t bcd_clamp(input bcd_t value);
      return (value > BCD_MAX) ? BCD_MAX : value;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit of the up/down ripple chain.
module bcd_digit
   import bcd_pkg::*;
(
   input  bcd_t value,
   input  logic carry_in,
   input  logic borrow_in,
   output bcd_t next_value,
   output logic carry_out,
   output logic borrow_out
);

   // Step this digit by the incoming carry or borrow and pass it on at 9->0 / 0->9.
   always_comb begin
      next_value = value;
      carry_out  = 1'b0;
      borrow_out = 1'b0;
      if (carry_in && !borrow_in) begin
         if (value >= BCD_MAX) begin
            next_value = BCD_MIN;
            carry_out  = 1'b1;
         end else begin
            next_value = value + 4'd1;
         end
      end else if (borrow_in && !carry_in) begin
         if (value == BCD_MIN) begin
            next_value = BCD_MAX;
            borrow_out = 1'b1;
         end else begin
            next_value = value - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, clear, wrap/saturate ends and flags.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int BCD_NUM = 8,
   parameter int WRAP    = 1
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 incr,
   input  logic                 decr,
   input  logic                 load,
   input  bcd_t [BCD_NUM-1:0]   load_bcds,
   input  logic                 reset_counter,
   output bcd_t [BCD_NUM-1:0]   bcds,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 at_zero,
   output logic                 at_max
);

   bcd_t [BCD_NUM-1:0] ripple;
   bcd_t [BCD_NUM-1:0] bcds_nxt;
   logic [BCD_NUM:0]   carry;
   logic [BCD_NUM:0]   borrow;
   logic               overflow_nxt;
   logic               underflow_nxt;
   logic               at_zero_nxt;
   logic               at_max_nxt;

   // incr together with decr cancels out, so neither chain is started.
   assign carry[0]  = incr & ~decr;
   assign borrow[0] = decr & ~incr;

   genvar g;
   generate
      for (g = 0; g < BCD_NUM; g++) begin : gen_digit
         bcd_digit u_digit (
            .value      (bcds[g]),
            .carry_in   (carry[g]),
            .borrow_in  (borrow[g]),
            .next_value (ripple[g]),
            .carry_out  (carry[g+1]),
            .borrow_out (borrow[g+1])
         );
      end
   endgenerate

   // Priority mux: clear, load, then count; a carry/borrow out of the top digit
   // marks a range end, where the rippled value is already the wrapped one.
   always_comb begin
      bcds_nxt      = bcds;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
      if (reset_counter) begin
         bcds_nxt = '0;
      end else if (load) begin
         for (int i = 0; i < BCD_NUM; i++)
            bcds_nxt[i] = bcd_clamp(load_bcds[i]);
      end else if (carry[BCD_NUM]) begin
         overflow_nxt = 1'b1;
         bcds_nxt     = (WRAP != 0) ? ripple : bcds;
      end else if (borrow[BCD_NUM]) begin
         underflow_nxt = 1'b1;
         bcds_nxt      = (WRAP != 0) ? ripple : bcds;
      end else begin
         bcds_nxt = ripple;
      end
   end

   // Flags come from the next value so they line up with bcds after the edge.
   always_comb begin
      at_zero_nxt = 1'b1;
      at_max_nxt  = 1'b1;
      for (int i = 0; i < BCD_NUM; i++) begin
         if (bcds_nxt[i] != BCD_MIN) at_zero_nxt = 1'b0;
         if (bcds_nxt[i] != BCD_MAX) at_max_nxt  = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bcds      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         at_zero   <= 1'b1;
         at_max    <= 1'b0;
      end else begin
         bcds      <= bcds_nxt;
         overflow  <= overflow_nxt;
         underflow <= underflow_nxt;
         at_zero   <= at_zero_nxt;
         at_max    <= at_max_nxt;
      end
   end

endmodule
